// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an MMIO window
// with an LED register, a free-running cycle counter and a byte TX FIFO.
module data_mem_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LEDS,
    SEL_CYCLES,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  sel_e          sel;
  logic [31:0]   mem [DEPTH];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycles;
  logic          overflow;
  logic          full;
  logic          push;
  logic          pop;
  logic          accept;
  logic          unused_addr_lsbs;

  // Byte offset within a word is irrelevant: every access is a full word.
  assign unused_addr_lsbs = ^ALUResult[1:0];

  // MMIO decode takes priority so a 1024-word RAM cannot shadow the I/O window.
  always_comb begin
    sel = SEL_NONE;
    case (ALUResult[31:2])
      30'h100: sel = SEL_LEDS;
      30'h101: sel = SEL_CYCLES;
      30'h102: sel = SEL_TXDATA;
      30'h103: sel = SEL_STATUS;
      default: if (ALUResult[31:AW+2] == '0) sel = SEL_RAM;
    endcase
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign tx_valid = (count != '0);
  assign tx_data  = fifo[rd_ptr];
  assign push     = MemWrite && (sel == SEL_TXDATA);
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign accept   = push && (!full || pop);

  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:    ReadData = mem[ALUResult[AW+1:2]];
      SEL_LEDS:   ReadData = {24'b0, leds};
      SEL_CYCLES: ReadData = cycles;
      SEL_STATUS: ReadData = {24'b0, overflow, 5'(count), full, ~tx_valid};
      default:    ReadData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (MemWrite && (sel == SEL_RAM)) mem[ALUResult[AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds   <= '0;
      cycles <= '0;
    end else begin
      if (MemWrite && (sel == SEL_LEDS)) leds <= WriteData[7:0];
      if (MemWrite && (sel == SEL_CYCLES)) cycles <= '0;
      else                                 cycles <= cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (MemWrite && (sel == SEL_STATUS) && WriteData[7])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic compared every cycle against a queue/array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned FD    = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        MemWrite  = 1'b0;
  logic        tx_ready  = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;

  data_mem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .leds(leds),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  leds_m = '0;
  logic [31:0] cyc_m  = '0;
  logic [7:0]  q [$];
  bit          ovf_m  = 1'b0;
  logic [31:0] ram_m [int];
  bit          skip_cyc = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] status_m();
    int sz = q.size();
    return (32'(ovf_m) << 7) | (32'(sz) << 2) | (32'(sz == FD) << 1) | 32'(sz == 0);
  endfunction

  function automatic void exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v     = '0;
    case (a[31:2])
      30'h100: v = {24'h0, leds_m};
      30'h101: v = cyc_m;
      30'h102: v = '0;
      30'h103: v = status_m();
      default: if (a < DEPTH * 4) begin
        if (ram_m.exists(int'(a >> 2))) v = ram_m[int'(a >> 2)];
        else known = 1'b0;
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int sz;
    bit pop;
    bit push;
    if (reset) begin
      leds_m = '0;
      cyc_m  = '0;
      ovf_m  = 1'b0;
      q.delete();
    end else begin
      sz   = q.size();
      pop  = (sz != 0) && tx_ready;
      push = MemWrite && (ALUResult[31:2] == 30'h102);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (sz < FD || pop) q.push_back(WriteData[7:0]);
        else ovf_m = 1'b1;
      end
      if (MemWrite && ALUResult[31:2] == 30'h103 && WriteData[7] && !(push && sz == FD && !pop))
        ovf_m = 1'b0;
      if (MemWrite && ALUResult[31:2] == 30'h100) leds_m = WriteData[7:0];
      cyc_m = (MemWrite && ALUResult[31:2] == 30'h101) ? 32'h0 : cyc_m + 32'd1;
      if (MemWrite && ALUResult < DEPTH * 4) ram_m[int'(ALUResult >> 2)] = WriteData;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ev;
    bit known;
    exp_read(ALUResult, ev, known);
    if (known && !(skip_cyc && ALUResult[31:2] == 30'h101)) chk("ReadData", ReadData, ev);
    chk("leds", {24'h0, leds}, {24'h0, leds_m});
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
  end

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
    tx_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    MemWrite  = 1'b0;
    ALUResult = a;
    #1;
    chk(name, ReadData, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 32'h40C, '0, 1'b0);
    tick();
    tick();
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_txvalid", 32'(tx_valid), 32'h0);
    rd_chk("rst_status", 32'h40C, 32'h1);

    ALUResult = 32'h404;
    reset     = 1'b0;
    repeat (10) tick();
    chk("cycles_10", ReadData, 32'd10);

    drive(1'b1, 32'h14, 32'hCAFEF00D, 1'b0); tick();
    drive(1'b1, 32'h00, 32'h01020304, 1'b0); tick();
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0); tick();
    drive(1'b1, 32'h13, 32'h12345678, 1'b0);
    #1 chk("ram_prewrite", ReadData, 32'hDEADBEEF);
    tick();
    rd_chk("ram_lowbits", 32'h10, 32'h12345678);
    rd_chk("ram_neighbor", 32'h14, 32'hCAFEF00D);

    drive(1'b1, 32'h400, 32'hFFFFFFA5, 1'b0); tick();
    chk("leds_A5", 32'(leds), 32'hA5);
    rd_chk("leds_read", 32'h400, 32'hA5);
    rd_chk("unmapped_read", 32'h800, 32'h0);
    drive(1'b1, 32'h800, 32'hFFFFFFFF, 1'b0); tick();
    rd_chk("unmapped_after_wr", 32'h800, 32'h0);
    rd_chk("ram0_after_unmapped", 32'h0, 32'h01020304);
    rd_chk("status_after_unmapped", 32'h40C, 32'h1);
    chk("leds_after_unmapped", 32'(leds), 32'hA5);

    drive(1'b1, 32'h404, 32'h12345678, 1'b0); tick();
    rd_chk("cycles_clear", 32'h404, 32'h0);
    tick();
    chk("cycles_inc", ReadData, 32'h1);

    skip_cyc = 1'b1;
    force dut.cycles = 32'hFFFFFFFF;
    #1 release dut.cycles;
    #1 chk("cycles_forced", ReadData, 32'hFFFFFFFF);
    tick();
    chk("cycles_wrap", ReadData, 32'h0);
    drive(1'b1, 32'h404, '0, 1'b0); tick();
    MemWrite = 1'b0;
    skip_cyc = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h408, {24'hABCDEF, 8'(17 * (i + 1))}, 1'b0);
      tick();
    end
    rd_chk("fifo_full_status", 32'h40C, 32'h12);
    drive(1'b1, 32'h408, 32'h55, 1'b0); tick();
    rd_chk("fifo_ovf_status", 32'h40C, 32'h92);
    rd_chk("txdata_read_zero", 32'h408, 32'h0);
    chk("txdata_no_pop", 32'(tx_data), 32'h11);
    ALUResult = 32'h40C;
    tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_data", 32'(tx_data), 32'(17 * (i + 1)));
      tick();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    chk("drain_status", ReadData, 32'h81);
    drive(1'b1, 32'h40C, 32'h80, 1'b0); tick();
    rd_chk("ovf_clear", 32'h40C, 32'h1);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h408, 32'(8'hA1 + i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h408, 32'h66, 1'b1); tick();
    drive(1'b0, 32'h40C, '0, 1'b0);
    #1 chk("full_pushpop_status", ReadData, 32'h12);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_pushpop_data", 32'(tx_data), (i < 3) ? 32'(8'hA2 + i) : 32'h66);
      tick();
    end
    chk("full_pushpop_empty", 32'(tx_valid), 32'h0);

    drive(1'b1, 32'h408, 32'h77, 1'b1); tick();
    drive(1'b0, 32'h40C, '0, 1'b0);
    #1 chk("empty_pushpop_status", ReadData, 32'h04);
    chk("empty_pushpop_data", 32'(tx_data), 32'h77);

    drive(1'b1, 32'h408, 32'h88, 1'b0); tick();
    drive(1'b1, 32'h408, 32'h99, 1'b0); tick();
    drive(1'b1, 32'h400, 32'hFF, 1'b0); tick();
    drive(1'b0, 32'h40C, '0, 1'b0);
    #1 chk("pre_reset_status", ReadData, 32'h0C);
    chk("pre_reset_leds", 32'(leds), 32'hFF);
    #1 reset = 1'b1;
    #1 chk("async_rst_txvalid", 32'(tx_valid), 32'h0);
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_status", ReadData, 32'h1);
    tick();
    tick();
    reset = 1'b0;
    rd_chk("ram_after_reset", 32'h10, 32'h12345678);
    rd_chk("ram_after_reset2", 32'h14, 32'hCAFEF00D);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      bit          rdy;
      case ($urandom_range(0, 9))
        0, 1, 2: a = 32'($urandom_range(0, DEPTH * 4 - 1));
        3:       a = 32'h400 | 32'($urandom_range(0, 3));
        4:       a = 32'h404;
        5, 6:    a = 32'h408 | 32'($urandom_range(0, 3));
        7:       a = 32'h40C;
        8:       a = 32'h800 + 32'($urandom_range(0, 255));
        default: a = 32'($urandom);
      endcase
      rdy = ($urandom_range(0, 99) < (((n / 100) % 2 == 1) ? 85 : 10));
      drive(1'($urandom_range(0, 1)), a, 32'($urandom), rdy);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
